// File: rtl/riscv_lsu_if.sv
// Core-side and memory-side signals of the load/store unit, bundled for port hookup.
// slave is the LSU's view; master is the surrounding core/memory view.
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        lsu_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, lsu_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o,
           mem_wd_o
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, lsu_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o,
           mem_wd_o
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding access, byte-enable/store-data formatting, load extension,
// misalignment rejection and optional BUSY timeout.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input logic          clk_i,
  input logic          rst_i,
  riscv_lsu_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic [15:0] cnt_q;
  logic        mem_req_q, mem_we_q, err_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q, mem_wd_q;

  logic        aligned;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        busy, timeout_hit;

  always_comb begin
    aligned = 1'b0;
    be_calc = 4'b0000;
    wd_calc = bus.core_wd_i;
    unique case (bus.core_size_i)
      3'd0, 3'd4: begin
        aligned = 1'b1;
        be_calc = 4'b0001 << bus.core_addr_i[1:0];
        wd_calc = {4{bus.core_wd_i[7:0]}};
      end
      3'd1, 3'd5: begin
        aligned = ~bus.core_addr_i[0];
        be_calc = bus.core_addr_i[1] ? 4'b1100 : 4'b0011;
        wd_calc = {2{bus.core_wd_i[15:0]}};
      end
      3'd2: begin
        aligned = (bus.core_addr_i[1:0] == 2'b00);
        be_calc = 4'b1111;
      end
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    ld_byte = 8'h00;
    unique case (off_q)
      2'd0: ld_byte = bus.mem_rd_i[7:0];
      2'd1: ld_byte = bus.mem_rd_i[15:8];
      2'd2: ld_byte = bus.mem_rd_i[23:16];
      2'd3: ld_byte = bus.mem_rd_i[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = off_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
    unique case (size_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_data = {24'h0, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_data = {16'h0, ld_half};
      default: ld_data = bus.mem_rd_i;
    endcase
  end

  assign busy = (state_q == StBusy);
  // Ready in the expiry cycle wins, so expiry requires ready low.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && busy && !bus.mem_ready_i && (cnt_q == TimeoutLast);

  assign bus.core_stall_o = busy ? (~bus.mem_ready_i & ~timeout_hit)
                                 : (bus.core_req_i & aligned);
  assign bus.core_rd_o    = (busy && (we_q || timeout_hit)) ? 32'h0 : ld_data;
  assign bus.lsu_err_o    = err_q;
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_be_o     = mem_be_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wd_o     = mem_wd_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      size_q     <= 3'd0;
      we_q       <= 1'b0;
      off_q      <= 2'd0;
      cnt_q      <= 16'd0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 4'b0000;
      mem_addr_q <= 32'h0;
      mem_wd_q   <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.core_req_i && aligned) begin
            state_q    <= StBusy;
            size_q     <= bus.core_size_i;
            we_q       <= bus.core_we_i;
            off_q      <= bus.core_addr_i[1:0];
            cnt_q      <= 16'd0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= bus.core_we_i;
            mem_be_q   <= be_calc;
            mem_addr_q <= {bus.core_addr_i[31:2], 2'b00};
            mem_wd_q   <= wd_calc;
          end else if (bus.core_req_i) begin
            err_q <= 1'b1;
          end
        end
        StBusy: begin
          if (bus.mem_ready_i) begin
            mem_req_q <= 1'b0;
            state_q   <= StIdle;
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            state_q   <= StIdle;
            err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu (timeout of 4 cycles) with a scoreboard queue of load results.
module tb_riscv_lsu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] exp_q[$];

  riscv_lsu_if bus ();

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd);
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = we;
    bus.core_size_i = size;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
  endtask

  // Full legal access with memory ready on BUSY cycle ready_at.
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int ready_at, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd);
    logic [31:0] e;
    drive_req(we, size, addr, wd);
    bus.mem_ready_i = 1'b0;
    #1;
    chk({tag, "_stall_req"}, 32'(bus.core_stall_o), 32'd1);
    exp_q.push_back(exp_rd);
    for (int k = 1; k <= ready_at; k++) begin
      step();
      if (k == 1) begin
        chk({tag, "_be"}, 32'(bus.mem_be_o), 32'(exp_be));
        chk({tag, "_addr"}, bus.mem_addr_o, {addr[31:2], 2'b00});
        chk({tag, "_we"}, 32'(bus.mem_we_o), 32'(we));
        chk({tag, "_wd"}, bus.mem_wd_o, exp_wd);
      end
      chk({tag, "_req"}, 32'(bus.mem_req_o), 32'd1);
      if (k == ready_at) begin
        bus.mem_ready_i = 1'b1;
        bus.mem_rd_i    = rdata;
        #1;
        chk({tag, "_stall_done"}, 32'(bus.core_stall_o), 32'd0);
        e = exp_q.pop_front();
        chk({tag, "_rd"}, bus.core_rd_o, e);
      end else begin
        bus.mem_rd_i = 32'h5A5A5A5A;
        #1;
        chk({tag, "_stall_busy"}, 32'(bus.core_stall_o), 32'd1);
      end
    end
    step();
    bus.core_req_i  = 1'b0;
    bus.mem_ready_i = 1'b0;
    chk({tag, "_req_drop"}, 32'(bus.mem_req_o), 32'd0);
    chk({tag, "_noerr"}, 32'(bus.lsu_err_o), 32'd0);
  endtask

  task automatic misalign(input string tag, input logic [2:0] size, input logic [31:0] addr);
    drive_req(1'b0, size, addr, 32'h0);
    #1;
    chk({tag, "_stall"}, 32'(bus.core_stall_o), 32'd0);
    step();
    bus.core_req_i = 1'b0;
    chk({tag, "_noreq"}, 32'(bus.mem_req_o), 32'd0);
    chk({tag, "_err"}, 32'(bus.lsu_err_o), 32'd1);
    step();
    chk({tag, "_err_clr"}, 32'(bus.lsu_err_o), 32'd0);
  endtask

  initial begin
    bus.core_req_i  = 1'b0;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = 3'd0;
    bus.core_addr_i = 32'h0;
    bus.core_wd_i   = 32'h0;
    bus.mem_rd_i    = 32'h0;
    bus.mem_ready_i = 1'b0;
    step();
    step();
    chk("rst_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_we", 32'(bus.mem_we_o), 32'd0);
    chk("rst_be", 32'(bus.mem_be_o), 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_wd", bus.mem_wd_o, 32'h0);
    chk("rst_err", 32'(bus.lsu_err_o), 32'd0);
    chk("rst_stall", 32'(bus.core_stall_o), 32'd0);
    rst = 1'b1;
    step();

    access("ldw", 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 3, 4'b1111, 32'h0, 32'hDEADBEEF);
    access("stb", 1'b1, 3'd0, 32'h203, 32'hA5, 32'hFFFFFFFF, 1, 4'b1000, 32'hA5A5A5A5, 32'h0);
    access("ldh", 1'b0, 3'd1, 32'h002, 32'h0, 32'h80010000, 1, 4'b1100, 32'h0, 32'hFFFF8001);
    access("ldhu", 1'b0, 3'd5, 32'h002, 32'h0, 32'h80010000, 1, 4'b1100, 32'h0, 32'h00008001);
    access("ldb", 1'b0, 3'd0, 32'h003, 32'h0, 32'h80010000, 2, 4'b1000, 32'h0, 32'hFFFFFF80);
    access("ldbu", 1'b0, 3'd4, 32'h401, 32'h0, 32'h0000F000, 1, 4'b0010, 32'h0, 32'h000000F0);
    access("sth", 1'b1, 3'd1, 32'h406, 32'hBEEF1234, 32'h0, 2, 4'b1100, 32'h12341234, 32'h0);
    access("stw", 1'b1, 3'd2, 32'h408, 32'hCAFEF00D, 32'h0, 1, 4'b1111, 32'hCAFEF00D, 32'h0);

    misalign("mis_w", 3'd2, 32'h102);
    misalign("mis_sz3", 3'd3, 32'h100);
    misalign("mis_hu", 3'd5, 32'h101);

    // Timeout: memory never ready.
    drive_req(1'b0, 3'd2, 32'h300, 32'h0);
    bus.mem_rd_i = 32'hFFFFFFFF;
    #1;
    chk("to_stall_req", 32'(bus.core_stall_o), 32'd1);
    exp_q.push_back(32'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("to_req", 32'(bus.mem_req_o), 32'd1);
      chk("to_stall", 32'(bus.core_stall_o), (k == 4) ? 32'd0 : 32'd1);
    end
    chk("to_rd", bus.core_rd_o, exp_q.pop_front());
    step();
    bus.core_req_i = 1'b0;
    chk("to_req_drop", 32'(bus.mem_req_o), 32'd0);
    chk("to_err", 32'(bus.lsu_err_o), 32'd1);
    step();
    chk("to_err_clr", 32'(bus.lsu_err_o), 32'd0);

    access("to_ready4", 1'b0, 3'd2, 32'h304, 32'h0, 32'h13579BDF, 4, 4'b1111, 32'h0, 32'h13579BDF);

    // Reset during the second BUSY cycle drops the access silently.
    drive_req(1'b0, 3'd2, 32'h500, 32'h0);
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.core_req_i = 1'b0;
    #1;
    chk("rb_req", 32'(bus.mem_req_o), 32'd0);
    chk("rb_err", 32'(bus.lsu_err_o), 32'd0);
    chk("rb_stall_lo", 32'(bus.core_stall_o), 32'd0);
    bus.core_req_i = 1'b1;
    #1;
    chk("rb_stall_hi", 32'(bus.core_stall_o), 32'd1);
    bus.core_req_i = 1'b0;
    #1;
    step();
    chk("rb_idle", 32'(bus.mem_req_o), 32'd0);
    chk("rb_err2", 32'(bus.lsu_err_o), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
